// File: rtl/boot_pkg.sv
// boot_pkg: state encoding and shared constants for the instruction-memory boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

    function automatic logic accepts(input state_e s);
        return s inside {HDR0, HDR1, DATA, CHK};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a byte stream, one-cycle word_valid pulse.
module byte_packer
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [7:0]        data_i,
    output logic [BIDX_W-1:0] byte_idx_o,
    output logic              word_valid_o,
    output logic [31:0]       word_o
);

    logic [BIDX_W-1:0] idx_q;
    logic [31:0]       lanes_q;
    logic [31:0]       word_q;
    logic              valid_q;
    logic              last;

    assign last = idx_q == BIDX_W'(BYTES_PER_WORD - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
        end else if (en_i && last) begin
            word_q <= {data_i, lanes_q[23:0]};
        end
        if (reset || clr_i) begin
            idx_q   <= '0;
            lanes_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en_i && last;
            if (en_i) begin
                idx_q                   <= idx_q + 1'b1;
                lanes_q[{idx_q, 3'b000} +: 8] <= data_i;
            end
        end
    end

    assign byte_idx_o   = idx_q;
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a counted byte image into instruction memory, holding the CPU in reset until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_e FIN = CHK;
`else
    localparam state_e FIN = DONE;
`endif

    state_e            state_q, state_d;
    logic              rdy_q, rdy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, hdr;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic              xfer, last_word, last_byte, reload_ok, pk_en, pk_clr;
    logic [BIDX_W-1:0] bidx;
    logic              word_valid;
    logic [31:0]       word;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign xfer      = rx_valid && rdy_q;
    assign hdr       = CNT_W'({rx_data, cnt_q[7:0]});
    assign last_word = CNT_W'(widx_q) == cnt_q - CNT_W'(1);
    assign reload_ok = reload && (state_q == DONE || state_q == ERR);
    assign pk_en     = state_q == DATA && xfer;
    assign pk_clr    = (state_q == HDR1 && xfer) || reload_ok;
    // Ready drops for the final write cycle so no stray byte enters the packer.
    assign last_byte = pk_en && bidx == BIDX_W'(BYTES_PER_WORD - 1) && last_word;

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (pk_clr),
        .en_i        (pk_en),
        .data_i      (rx_data),
        .byte_idx_o  (bidx),
        .word_valid_o(word_valid),
        .word_o      (word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        case (state_q)
            HDR0: if (xfer) begin
                cnt_d[7:0] = rx_data;
                state_d    = HDR1;
            end
            HDR1: if (xfer) begin
                cnt_d   = hdr;
                widx_d  = '0;
                state_d = hdr == '0 ? FIN : hdr > DEPTH ? ERR : DATA;
            end
            DATA: if (word_valid) begin
                widx_d  = widx_q + 1'b1;
                state_d = last_word ? FIN : DATA;
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            CHK: if (xfer) state_d = rx_data == csum_q ? DONE : ERR;
`endif
            DONE, ERR: if (reload) begin
                state_d = HDR0;
                cnt_d   = '0;
                widx_d  = '0;
            end
            default: ;
        endcase
        rdy_d = accepts(state_d) && !last_byte;
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    assign csum_d = pk_clr ? 8'h00 : pk_en ? csum_q ^ rx_data : csum_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HDR0;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            widx_q  <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign rx_ready   = rdy_q;
    assign imem_we    = word_valid;
    assign imem_addr  = widx_q;
    assign imem_wdata = word;
    assign cpu_reset  = state_q != DONE;
    assign load_done  = state_q == DONE;
    assign load_err   = state_q == ERR;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader; checksum scenarios under IMEM_BOOT_CHECKSUM_EN.
module tb_imem_boot_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              reload = 1'b0;
    logic              rx_ready, imem_we, cpu_reset, load_done, load_err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] mon_e;
    logic [7:0] img [8];
    logic [7:0] img_xor;

    imem_boot_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected addr=%0d data=%h required no write", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== mon_e)
                    $display("FAIL write addr/data=%0d/%h required %0d/%h", imem_addr, imem_wdata,
                             mon_e[ADDR_W+31:32], mon_e[31:0]);
                else pass_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired pass=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total_cnt++;
            $display("FAIL send_timeout byte=%h rx_ready=%b required 1", b, rx_ready);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; rx_valid = 1'b0; reload = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_img();
        exp_q.push_back({6'd0, img[3], img[2], img[1], img[0]});
        exp_q.push_back({6'd1, img[7], img[6], img[5], img[4]});
    endtask

    task automatic send_img(input bit gap);
        for (int i = 0; i < 8; i++) begin
            send(img[i]);
            if (gap) begin
                @(negedge clk);
                total_cnt++;
                if (imem_we !== ((i % 4) == 3))
                    $display("FAIL toggle_we byte=%0d imem_we=%b required %b", i, imem_we, (i % 4) == 3);
                else pass_cnt++;
            end
        end
    endtask

    task automatic check_done(input string tag);
        total_cnt++;
        if ({load_done, cpu_reset, load_err, rx_ready} !== 4'b1000)
            $display("FAIL %s_done done/cpu_reset/err/ready=%b%b%b%b required 1000", tag,
                     load_done, cpu_reset, load_err, rx_ready);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s_pending writes left=%0d required 0", tag, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err} !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_vals ready/we/addr/wdata/cpu_rst/done/err=%b/%b/%0d/%h/%b/%b/%b required 0/0/0/0/1/0/0",
                     rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (rx_ready !== 1'b1 || cpu_reset !== 1'b1)
            $display("FAIL reset_release rx_ready/cpu_reset=%b/%b required 1/1", rx_ready, cpu_reset);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_img();
        send(8'h02); send(8'h00);
        send_img(1'b0);
        @(negedge clk);
        total_cnt++;
        if (imem_we !== 1'b1 || load_done !== 1'b0)
            $display("FAIL b2b_last_write we/done=%b/%b required 1/0", imem_we, load_done);
        else pass_cnt++;
`ifdef IMEM_BOOT_CHECKSUM_EN
        send(img_xor);
`endif
        @(negedge clk);
        check_done("b2b");
        rx_data = 8'hFF; rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        check_done("b2b_idle");
    endtask

    task automatic test_toggle();
        do_reset();
        push_img();
        send(8'h02); send(8'h00);
        send_img(1'b1);
`ifdef IMEM_BOOT_CHECKSUM_EN
        send(img_xor);
`endif
        @(negedge clk);
        check_done("toggle");
    endtask

    task automatic test_overflow();
        do_reset();
        send(8'h41); send(8'h00);
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({load_err, cpu_reset, rx_ready, load_done} !== 4'b1100)
            $display("FAIL overflow err/cpu_reset/ready/done=%b%b%b%b required 1100",
                     load_err, cpu_reset, rx_ready, load_done);
        else pass_cnt++;
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({load_err, cpu_reset, rx_ready, load_done} !== 4'b0110)
            $display("FAIL overflow_reload err/cpu_reset/ready/done=%b%b%b%b required 0110",
                     load_err, cpu_reset, rx_ready, load_done);
        else pass_cnt++;
    endtask

    task automatic test_full_depth();
        logic [31:0] w;
        logic [7:0]  x;
        x = 8'h00;
        do_reset();
        send(8'h40); send(8'h00);
        for (int i = 0; i < 64; i++) begin
            w = {8'(i), 8'hA5, 8'(~i), 8'(i * 3)};
            exp_q.push_back({6'(i), w});
            for (int k = 0; k < 4; k++) begin
                send(w[k*8 +: 8]);
                x = x ^ w[k*8 +: 8];
            end
        end
        @(negedge clk);
`ifdef IMEM_BOOT_CHECKSUM_EN
        send(x);
`endif
        @(negedge clk);
        check_done("full64");
    endtask

    task automatic test_abort();
        do_reset();
        exp_q.push_back({6'd0, img[3], img[2], img[1], img[0]});
        send(8'h02); send(8'h00);
        for (int i = 0; i < 6; i++) send(img[i]);
        do_reset();
        total_cnt++;
        if (exp_q.size() != 0 || cpu_reset !== 1'b1 || load_done !== 1'b0)
            $display("FAIL abort left=%0d cpu_reset=%b done=%b required 0/1/0", exp_q.size(), cpu_reset, load_done);
        else pass_cnt++;
        exp_q.push_back({6'd0, img[7], img[6], img[5], img[4]});
        send(8'h01); send(8'h00);
        for (int i = 4; i < 8; i++) send(img[i]);
        @(negedge clk);
`ifdef IMEM_BOOT_CHECKSUM_EN
        send(img[4] ^ img[5] ^ img[6] ^ img[7]);
`endif
        @(negedge clk);
        check_done("abort_reload");
    endtask

    task automatic test_empty();
        do_reset();
        send(8'h00); send(8'h00);
`ifdef IMEM_BOOT_CHECKSUM_EN
        @(negedge clk);
        total_cnt++;
        if (load_done !== 1'b0 || rx_ready !== 1'b1)
            $display("FAIL empty_chk done/ready=%b/%b required 0/1", load_done, rx_ready);
        else pass_cnt++;
        send(8'h00);
`endif
        @(negedge clk);
        check_done("empty");
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum_bad();
        do_reset();
        push_img();
        send(8'h02); send(8'h00);
        send_img(1'b0);
        send(8'h00);
        @(negedge clk);
        total_cnt++;
        if ({load_err, cpu_reset, rx_ready, load_done} !== 4'b1100)
            $display("FAIL csum_bad err/cpu_reset/ready/done=%b%b%b%b required 1100",
                     load_err, cpu_reset, rx_ready, load_done);
        else pass_cnt++;
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({load_err, cpu_reset, rx_ready} !== 3'b011)
            $display("FAIL csum_reload err/cpu_reset/ready=%b%b%b required 011", load_err, cpu_reset, rx_ready);
        else pass_cnt++;
    endtask
`endif

    initial begin
        img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        img_xor = 8'h00;
        for (int i = 0; i < 8; i++) img_xor = img_xor ^ img[i];
        test_reset();
        test_back_to_back();
        test_toggle();
        test_overflow();
        test_abort();
        test_empty();
        test_full_depth();
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum_bad();
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
